// File: rtl/controlador_display.sv
// rtl/controlador_display.sv - 4-digit seven-segment scan controller with blanking gaps and per-frame snapshot; optional LEADING_ZERO_BLANK_EN
module controlador_display #(
    parameter int SHOW_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [15:0]    sh_data;
    logic [3:0]     sh_dp;
    logic [3:0]     sh_en;

    logic           snap;
    logic [15:0]    nx_data;
    logic [3:0]     nx_dp;
    logic [3:0]     nx_en;
    logic [3:0]     nibble;
    logic           lz_dark;
    logic           visible;

    function automatic logic [6:0] hex7seg(input logic [3:0] v);
        case (v)
            4'h0: hex7seg = 7'b1000000;
            4'h1: hex7seg = 7'b1111001;
            4'h2: hex7seg = 7'b0100100;
            4'h3: hex7seg = 7'b0110000;
            4'h4: hex7seg = 7'b0011001;
            4'h5: hex7seg = 7'b0010010;
            4'h6: hex7seg = 7'b0000010;
            4'h7: hex7seg = 7'b1111000;
            4'h8: hex7seg = 7'b0000000;
            4'h9: hex7seg = 7'b0010000;
            4'hA: hex7seg = 7'b0001000;
            4'hB: hex7seg = 7'b0000011;
            4'hC: hex7seg = 7'b1000110;
            4'hD: hex7seg = 7'b0100001;
            4'hE: hex7seg = 7'b0000110;
            default: hex7seg = 7'b0001110;
        endcase
    endfunction

    // Values the upcoming digit will display: fresh inputs at the frame snapshot edge, shadows otherwise
    always_comb begin
        snap    = (state == BLANK) && (cnt == BLANK_LAST) && (sel == 2'd0);
        nx_data = snap ? data     : sh_data;
        nx_dp   = snap ? dp_in    : sh_dp;
        nx_en   = snap ? digit_en : sh_en;
        nibble  = nx_data[{sel, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        case (sel)
            2'd3:    lz_dark = (nx_data[15:12] == 4'h0);
            2'd2:    lz_dark = (nx_data[15:8]  == 8'h00);
            2'd1:    lz_dark = (nx_data[15:4]  == 12'h000);
            default: lz_dark = 1'b0;
        endcase
`else
        lz_dark = 1'b0;
`endif
        visible = nx_en[sel] && (!lz_dark || nx_dp[sel]);
    end

    // Scan FSM; outputs are registered alongside the state so the pins never glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BLANK;
            cnt         <= '0;
            sel         <= 2'd0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            frame_start <= 1'b0;
            sh_data     <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= SHOW;
                        cnt   <= '0;
                        if (snap) begin
                            sh_data     <= data;
                            sh_dp       <= dp_in;
                            sh_en       <= digit_en;
                            frame_start <= 1'b1;
                        end
                        if (visible) begin
                            an  <= ~(4'b0001 << sel);
                            seg <= hex7seg(nibble);
                            dp  <= ~nx_dp[sel];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == SHOW_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        sel   <= sel + 2'd1;
                        an    <= 4'b1111;
                        seg   <= 7'b1111111;
                        dp    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_display.sv
// tb/tb_controlador_display.sv - self-checking bench for controlador_display against a slot-timing reference model
module tb_controlador_display;

    localparam int S = 4;
    localparam int B = 2;
    localparam int P = 4 * (S + B);

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // cycles since the last reset edge, and the model's copy of the frame snapshot
    int          k = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_en = '0;
    logic [14:0] exp_v;
    logic [14:0] got_v;

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    controlador_display #(.SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .digit_en(digit_en),
        .sel(sel), .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Expected {sel, an, seg, dp, frame_start} for position k, derived from slot arithmetic
    function automatic logic [14:0] model_out(input int kk);
        int p, q, d, r, s_exp;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fs, vis, dark;
        p     = kk % P;
        s_exp = (((p + P - (B + S)) % P) / (S + B) + 1) % 4;
        e_an  = 4'b1111;
        e_seg = 7'b1111111;
        e_dp  = 1'b1;
        e_fs  = (kk > 0) && (p == B);
        if (p >= B) begin
            q = p - B;
            d = q / (S + B);
            r = q % (S + B);
            if (r < S) begin
                dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                dark = (d > 0) && ((m_data >> (4 * d)) == 0);
`endif
                vis = m_en[d] && (!dark || m_dp[d]);
                if (vis) begin
                    e_an  = ~(4'b0001 << d);
                    e_seg = hex_tab[(m_data >> (4 * d)) & 16'hF];
                    e_dp  = ~m_dp[d];
                end
            end
        end
        return {2'(s_exp), e_an, e_seg, e_dp, e_fs};
    endfunction

    function automatic bit in_blank(input int kk);
        int p;
        p = kk % P;
        return (p < B) || (((p - B) % (S + B)) >= S);
    endfunction

    // Advance one clock and keep the model in step; inputs are stable at the edge
    task automatic step();
        @(posedge clk);
        if (reset) begin
            k = 0; m_data = '0; m_dp = '0; m_en = '0;
        end else begin
            k = k + 1;
            if (k % P == B) begin
                m_data = data; m_dp = dp_in; m_en = digit_en;
            end
        end
        #1;
        exp_v = model_out(k);
        got_v = {sel, an, seg, dp, frame_start};
    endtask

    task automatic test_reset();
        reset = 1'b1; data = 16'hFFFF; dp_in = 4'hF; digit_en = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (got_v !== 15'b00_1111_1111111_1_0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, got_v, 15'b00_1111_1111111_1_0);
            end
        end
    endtask

    task automatic test_scan();
        int fs_count = 0;
        data = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0;
        reset = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            fs_count += frame_start;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL scan k=%0d: got %b expected %b", k, got_v, exp_v);
            end
            if (k == B) begin
                checks++;
                if (an !== 4'b1110 || seg !== 7'b0001110) begin
                    errors++;
                    $display("FAIL scan_digit0_F: got an=%b seg=%b expected an=1110 seg=0001110", an, seg);
                end
            end
            if (k == B + S + B) begin
                checks++;
                if (an !== 4'b1101 || seg !== 7'b0001000) begin
                    errors++;
                    $display("FAIL scan_digit1_A: got an=%b seg=%b expected an=1101 seg=0001000", an, seg);
                end
            end
        end
        checks++;
        if (fs_count != 2) begin
            errors++;
            $display("FAIL scan_frame_start_count: got %0d expected 2", fs_count);
        end
    endtask

    task automatic test_anti_tearing();
        data = 16'h1234;
        for (int i = 0; i < 2 * P && (k % P) != B + (S + B) + 1; i++) begin
            step();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL tearing_pre k=%0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        data = 16'h5678;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL tearing k=%0d: got %b expected %b", k, got_v, exp_v);
            end
            if ((k % P) == B + 2 * (S + B) && i < P) begin
                checks++;
                if (seg !== 7'b0100100) begin
                    errors++;
                    $display("FAIL tearing_digit2_old: got seg=%b expected 0100100", seg);
                end
            end
        end
    endtask

    task automatic test_mask_dp();
        data = 16'h8888; digit_en = 4'b0101; dp_in = 4'b0100;
        for (int i = 0; i < 2 * P; i++) begin
            step();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL mask_dp k=%0d: got %b expected %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_midscan_reset();
        for (int i = 0; i < 2 * P && (k % P) != B + 2 * (S + B) + 1; i++) begin
            step();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL midreset_pre k=%0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        reset = 1'b1;
        step();
        checks++;
        if (an !== 4'b1111 || sel !== 2'd0) begin
            errors++;
            $display("FAIL midreset_abort: got an=%b sel=%0d expected an=1111 sel=0", an, sel);
        end
        reset = 1'b0;
        for (int i = 0; i < P + 4; i++) begin
            step();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL midreset_restart k=%0d: got %b expected %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] want_an3;
`ifdef LEADING_ZERO_BLANK_EN
        want_an3 = 4'b1111;
`else
        want_an3 = 4'b0111;
`endif
        digit_en = 4'hF; dp_in = 4'h0;
        for (int pass = 0; pass < 2; pass++) begin
            data = (pass == 0) ? 16'h0040 : 16'h0000;
            for (int i = 0; i < 2 * P; i++) begin
                step();
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL lead_zero k=%0d data=%h: got %b expected %b", k, data, got_v, exp_v);
                end
                if (i >= P && (k % P) == B + 3 * (S + B)) begin
                    checks++;
                    if (an !== want_an3) begin
                        errors++;
                        $display("FAIL lead_zero_digit3 data=%h: got an=%b expected %b", data, an, want_an3);
                    end
                end
            end
        end
    endtask

    task automatic test_invariant();
        for (int i = 0; i < 10 * P; i++) begin
            data = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'($urandom);
            if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
            step();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random k=%0d: got %b expected %b", k, got_v, exp_v);
            end
            checks++;
            if ($countones(~an) > 1 || (in_blank(k) && an !== 4'b1111)) begin
                errors++;
                $display("FAIL anode_invariant k=%0d: got an=%b expected at most one low and none in blank", k, an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_anti_tearing();
        test_mask_dp();
        test_midscan_reset();
        test_leading_zero();
        test_invariant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
